stream_keep_compactor: RTL and testbench
========================================

Name: stream_keep_compactor

Overview:
- Per-beat byte compactor placed directly upstream of the stream normalizer.
- Takes an AXI4S stream whose tkeep may be sparse, with kept bytes in any lanes.
- Moves the kept bytes of each beat, in ascending lane order, into the lowest lanes, so every output tkeep is a contiguous low-justified mask. This is the form the normalizer's popcount-driven barrel shift requires.
- Pure per-beat operation: no bytes ever cross a beat boundary. The block is a 2-stage pipeline with full AXI4S backpressure and sustains 1 beat/cycle.

Parameters:
- WIDTH, 512, data width in bits; a multiple of 8, at least 16. BYTES = WIDTH/8.
- DROP_EMPTY, 1, when 1, beats with tkeep==0 and tlast==0 are discarded; when 0, they are forwarded with tkeep 0.

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset; asynchronous assert, active-low
- i_data  AXI4S.s  tdata WIDTH / tkeep BYTES / tlast 1 / tvalid 1 / tready 1  input stream; arbitrary tkeep
- o_data  AXI4S.m  tdata WIDTH / tkeep BYTES / tlast 1 / tvalid 1 / tready 1  compacted stream to the normalizer

Behaviour:
- Interface: one clock aclk. Reset aresetn is asynchronous and active-low; all state registers use async clear.
- Reset values:
  - s1_valid=0, s2_valid (= o_data.tvalid)=0, o_data.tkeep=0, o_data.tlast=0, o_data.tdata=0.
  - i_data.tready evaluates to 1 while in reset.
- Stage 1, capture:
  - On i_data handshake, register tdata, tkeep and tlast.
  - Also register pos[i] = popcount(tkeep[i-1:0]) for every lane i (exclusive prefix sum, width $clog2(BYTES)+1) and cnt = popcount(tkeep).
- Stage 2, scatter:
  - Output lane j takes input byte i where tkeep[i]==1 and pos[i]==j. At most one i matches per j.
  - Lanes j >= cnt are driven to 0x00.
  - o_data.tkeep = (1<<cnt)-1. cnt==BYTES yields all ones; there must be no overflow in the shift.
  - o_data.tlast = the registered tlast.
- Latency: exactly 2 cycles from input handshake to o_data.tvalid when there is no backpressure.
- Handshake:
  - Stage 2 loads when !s2_valid || o_data.tready.
  - Stage 1 advances into stage 2 under the same condition.
  - i_data.tready = !s1_valid || (!s2_valid || o_data.tready).
  - Combinational paths are allowed: o_data.tready to i_data.tready, and i_data.tvalid to nothing.
  - o_data is held stable (tdata, tkeep, tlast) while tvalid && !tready.
- Throughput: with o_data.tready held at 1, one beat per cycle with no bubbles.
- Empty beats:
  - tkeep==0 && tlast==1: always forwarded with tkeep=0, tlast=1.
  - tkeep==0 && tlast==0 with DROP_EMPTY=1: accepted at the input (tready honoured) and dropped at the stage1->stage2 transfer. s2_valid is not set for it.
- Full beat (tkeep all ones): forwarded byte-identical.
- Order: beat order and tlast position are preserved exactly. The block never merges or splits beats.
- Simultaneous events: stage 2 emits and stage 1 refills in the same cycle under tready=1, with no bubble.
- Reset mid-operation: all in-flight beats are discarded and valids clear immediately (asynchronously). After deassertion, the first output is the first beat accepted after reset.

Test Plan:
- WIDTH=32, one beat tdata=0xDDCCBBAA, tkeep=4'b1010, tlast=1 -> 2 cycles later o_data.tdata=0x0000DDBB, tkeep=4'b0011, tlast=1.
- WIDTH=32, 3 back-to-back beats with tkeep 4'b1111, 4'b0100, 4'b1001, data 0x44332211, 0x00770000, 0x99000088, tready=1 -> outputs on 3 consecutive cycles: 0x44332211/1111, 0x00000077/0001, 0x00009988/0011.
- tready=0 for 5 cycles while 4 beats are offered -> exactly 2 beats accepted, i_data.tready=0 afterwards, o_data held stable. After tready=1, all 4 beats emerge in order with no loss or duplication.
- DROP_EMPTY=1, beats with tkeep 0001/0000/0000+tlast -> outputs are 0001 (tlast=0), then 0000 with tlast=1. The middle beat never appears.
- Assert aresetn=0 mid-stream with 2 beats in flight -> o_data.tvalid drops to 0 without waiting for a clock edge. After release, the first output equals the first post-reset input.
- Random sparse tkeep, WIDTH=512, random tready, 10k beats -> output matches a reference model (per beat, kept bytes in lane order, low-justified), and every o_data.tkeep is of the form 2^n-1.

Source files
------------

// File: rtl/stream_keep_compactor.sv
// Byte compactor: packs the kept bytes of each AXI4S beat into the lowest lanes.
// Two-stage pipeline (capture + prefix sums, then scatter) with full backpressure.
module stream_keep_compactor #(
  parameter int WIDTH      = 512,
  parameter bit DROP_EMPTY = 1'b1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [WIDTH-1:0]   i_data_tdata,
  input  logic [WIDTH/8-1:0] i_data_tkeep,
  input  logic               i_data_tlast,
  input  logic               i_data_tvalid,
  output logic               i_data_tready,
  output logic [WIDTH-1:0]   o_data_tdata,
  output logic [WIDTH/8-1:0] o_data_tkeep,
  output logic               o_data_tlast,
  output logic               o_data_tvalid,
  input  logic               o_data_tready
);
  localparam int BYTES = WIDTH / 8;
  localparam int CW    = $clog2(BYTES) + 1;

  logic                      s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]          s1_data_q, s1_data_d;
  logic [BYTES-1:0]          s1_keep_q, s1_keep_d;
  logic                      s1_last_q, s1_last_d;
  logic [BYTES-1:0][CW-1:0]  s1_pos_q, s1_pos_d;
  logic [CW-1:0]             s1_cnt_q, s1_cnt_d;

  logic                      s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]          s2_data_q, s2_data_d;
  logic [BYTES-1:0]          s2_keep_q, s2_keep_d;
  logic                      s2_last_q, s2_last_d;

  logic [BYTES-1:0][CW-1:0]  pfx_pos_s;
  logic [CW-1:0]             pfx_cnt_s;
  logic [WIDTH-1:0]          scat_data_s;
  logic [BYTES-1:0]          scat_keep_s;
  logic                      s2_load_s;
  logic                      s1_drop_s;

  assign s2_load_s     = !s2_valid_q || o_data_tready;
  assign i_data_tready = !s1_valid_q || s2_load_s;
  assign s1_drop_s     = DROP_EMPTY && (s1_keep_q == '0) && !s1_last_q;

  assign o_data_tvalid = s2_valid_q;
  assign o_data_tdata  = s2_data_q;
  assign o_data_tkeep  = s2_keep_q;
  assign o_data_tlast  = s2_last_q;

  // Exclusive prefix popcount of the input keep: destination lane of each kept byte.
  always_comb begin
    pfx_pos_s = '0;
    pfx_cnt_s = '0;
    for (int i = 0; i < BYTES; i++) begin
      pfx_pos_s[i] = pfx_cnt_s;
      pfx_cnt_s    = pfx_cnt_s + CW'(i_data_tkeep[i]);
    end
  end

  // Stage 1 next state: capture a beat whenever the input handshake fires.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_keep_d  = s1_keep_q;
    s1_last_d  = s1_last_q;
    s1_pos_d   = s1_pos_q;
    s1_cnt_d   = s1_cnt_q;
    if (i_data_tready) begin
      s1_valid_d = i_data_tvalid;
      if (i_data_tvalid) begin
        s1_data_d = i_data_tdata;
        s1_keep_d = i_data_tkeep;
        s1_last_d = i_data_tlast;
        s1_pos_d  = pfx_pos_s;
        s1_cnt_d  = pfx_cnt_s;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Scatter: byte i lands in lane pos[i]; since pos[i] <= i only i >= j can feed lane j.
  always_comb begin
    scat_data_s = '0;
    scat_keep_s = '0;
    for (int j = 0; j < BYTES; j++) begin
      scat_keep_s[j] = (CW'(j) < s1_cnt_q);
      for (int i = j; i < BYTES; i++) begin
        if (s1_keep_q[i] && (s1_pos_q[i] == CW'(j))) begin
          scat_data_s[8*j +: 8] = scat_data_s[8*j +: 8] | s1_data_q[8*i +: 8];
        end else begin
          scat_data_s[8*j +: 8] = scat_data_s[8*j +: 8];
        end
      end
    end
  end

  // Stage 2 next state: load the compacted beat; empty non-last beats may vanish here.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_keep_d  = s2_keep_q;
    s2_last_d  = s2_last_q;
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q && !s1_drop_s;
      if (s1_valid_q && !s1_drop_s) begin
        s2_data_d = scat_data_s;
        s2_keep_d = scat_keep_s;
        s2_last_d = s1_last_q;
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_keep_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_pos_q   <= '0;
      s1_cnt_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_keep_q  <= s1_keep_d;
      s1_last_q  <= s1_last_d;
      s1_pos_q   <= s1_pos_d;
      s1_cnt_q   <= s1_cnt_d;
    end
  end

  // Stage 2 registers drive the output stream directly.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_keep_q  <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_keep_q  <= s2_keep_d;
      s2_last_q  <= s2_last_d;
    end
  end

endmodule

// File: tb/tb_stream_keep_compactor.sv
// Directed and randomized checks for stream_keep_compactor at WIDTH=32, DROP_EMPTY=1.
module tb_stream_keep_compactor;
  localparam int W = 32;
  localparam int B = 4;
  localparam int N_RAND = 500;

  typedef struct {
    logic [W-1:0] d;
    logic [B-1:0] k;
    logic         l;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [W-1:0] i_tdata;
  logic [B-1:0] i_tkeep;
  logic         i_tlast;
  logic         i_tvalid;
  logic         i_tready;
  logic [W-1:0] o_tdata;
  logic [B-1:0] o_tkeep;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 aclk = ~aclk;

  stream_keep_compactor #(.WIDTH(W), .DROP_EMPTY(1'b1)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .i_data_tdata  (i_tdata),
    .i_data_tkeep  (i_tkeep),
    .i_data_tlast  (i_tlast),
    .i_data_tvalid (i_tvalid),
    .i_data_tready (i_tready),
    .o_data_tdata  (o_tdata),
    .o_data_tkeep  (o_tkeep),
    .o_data_tlast  (o_tlast),
    .o_data_tvalid (o_tvalid),
    .o_data_tready (o_tready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [B-1:0] k, input logic l);
    i_tvalid = v;
    i_tdata  = d;
    i_tkeep  = k;
    i_tlast  = l;
  endtask

  // Reference packing: kept bytes in ascending lane order, mask filled bit by bit.
  function automatic logic [W+B-1:0] compact(input logic [W-1:0] d, input logic [B-1:0] k);
    logic [W-1:0] od;
    logic [B-1:0] ok;
    int n;
    od = '0;
    ok = '0;
    n  = 0;
    for (int i = 0; i < B; i++) begin
      if (k[i]) begin
        od[8*n +: 8] = d[8*i +: 8];
        ok[n] = 1'b1;
        n++;
      end
    end
    return {ok, od};
  endfunction

  task automatic test_reset();
    aresetn  = 1'b0;
    o_tready = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    #2;
    total_cnt++; if (o_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b want 0", o_tvalid); else pass_cnt++;
    total_cnt++; if (o_tkeep !== 4'h0) $display("FAIL reset_tkeep: got %b want 0000", o_tkeep); else pass_cnt++;
    total_cnt++; if (o_tlast !== 1'b0) $display("FAIL reset_tlast: got %0b want 0", o_tlast); else pass_cnt++;
    total_cnt++; if (o_tdata !== 32'h0) $display("FAIL reset_tdata: got %h want 00000000", o_tdata); else pass_cnt++;
    total_cnt++; if (i_tready !== 1'b1) $display("FAIL reset_tready: got %0b want 1", i_tready); else pass_cnt++;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    o_tready = 1'b1;
    drive(1'b1, 32'hDDCCBBAA, 4'b1010, 1'b1);
    #1;
    total_cnt++; if (i_tready !== 1'b1) $display("FAIL single_tready: got %0b want 1", i_tready); else pass_cnt++;
    total_cnt++; if (o_tvalid !== 1'b0) $display("FAIL single_lat0: got %0b want 0", o_tvalid); else pass_cnt++;
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    total_cnt++; if (o_tvalid !== 1'b0) $display("FAIL single_lat1: got %0b want 0", o_tvalid); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (o_tvalid !== 1'b1) $display("FAIL single_lat2: got %0b want 1", o_tvalid); else pass_cnt++;
    total_cnt++; if (o_tdata !== 32'h0000DDBB) $display("FAIL single_tdata: got %h want 0000ddbb", o_tdata); else pass_cnt++;
    total_cnt++; if (o_tkeep !== 4'b0011) $display("FAIL single_tkeep: got %b want 0011", o_tkeep); else pass_cnt++;
    total_cnt++; if (o_tlast !== 1'b1) $display("FAIL single_tlast: got %0b want 1", o_tlast); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] in_d  [3] = '{32'h44332211, 32'h00770000, 32'h99000088};
    logic [B-1:0] in_k  [3] = '{4'b1111, 4'b0100, 4'b1001};
    logic [W-1:0] exp_d [3] = '{32'h44332211, 32'h00000077, 32'h00009988};
    logic [B-1:0] exp_k [3] = '{4'b1111, 4'b0001, 4'b0011};
    o_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b1, in_d[c], in_k[c], 1'b0);
      else drive(1'b0, 32'h0, 4'h0, 1'b0);
      #1;
      if (c >= 2 && c <= 4) begin
        total_cnt++; if (o_tvalid !== 1'b1) $display("FAIL b2b_tvalid[%0d]: got %0b want 1", c-2, o_tvalid); else pass_cnt++;
        total_cnt++; if (o_tdata !== exp_d[c-2] || o_tkeep !== exp_k[c-2])
          $display("FAIL b2b_beat[%0d]: got %h/%b want %h/%b", c-2, o_tdata, o_tkeep, exp_d[c-2], exp_k[c-2]);
        else pass_cnt++;
      end
      if (c == 5) begin
        total_cnt++; if (o_tvalid !== 1'b0) $display("FAIL b2b_idle: got %0b want 0", o_tvalid); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] in_d  [4] = '{32'h11223344, 32'hAABBCCDD, 32'h55667788, 32'h0F0E0D0C};
    logic [B-1:0] in_k  [4] = '{4'b0110, 4'b1111, 4'b1000, 4'b0101};
    logic         in_l  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_d [4] = '{32'h00002233, 32'hAABBCCDD, 32'h00000055, 32'h00000E0C};
    logic [B-1:0] exp_k [4] = '{4'b0011, 4'b1111, 4'b0001, 4'b0011};
    int  k   = 0;
    int  n   = 0;
    logic acc = 1'b0;
    o_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (acc) k++;
      if (k < 4) drive(1'b1, in_d[k], in_k[k], in_l[k]);
      else drive(1'b0, 32'h0, 4'h0, 1'b0);
      #1;
      acc = i_tvalid && i_tready;
      if (c >= 2) begin
        total_cnt++; if (o_tvalid !== 1'b1 || o_tdata !== exp_d[0] || o_tkeep !== exp_k[0] || o_tlast !== 1'b0)
          $display("FAIL bp_hold[%0d]: got %0b %h/%b/%0b want 1 %h/%b/0", c, o_tvalid, o_tdata, o_tkeep, o_tlast, exp_d[0], exp_k[0]);
        else pass_cnt++;
      end
      tick();
    end
    if (acc) k++;
    drive(1'b1, in_d[k], in_k[k], in_l[k]);
    #1;
    total_cnt++; if (k !== 2) $display("FAIL bp_accepted: got %0d want 2", k); else pass_cnt++;
    total_cnt++; if (i_tready !== 1'b0) $display("FAIL bp_tready: got %0b want 0", i_tready); else pass_cnt++;
    acc = 1'b0;
    tick();
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (acc) k++;
      if (k < 4) drive(1'b1, in_d[k], in_k[k], in_l[k]);
      else drive(1'b0, 32'h0, 4'h0, 1'b0);
      o_tready = 1'b1;
      #1;
      acc = i_tvalid && i_tready;
      if (o_tvalid) begin
        total_cnt++; if (o_tdata !== exp_d[n] || o_tkeep !== exp_k[n] || o_tlast !== in_l[n])
          $display("FAIL bp_out[%0d]: got %h/%b/%0b want %h/%b/%0b", n, o_tdata, o_tkeep, o_tlast, exp_d[n], exp_k[n], in_l[n]);
        else pass_cnt++;
        n++;
      end
      tick();
    end
    total_cnt++; if (n !== 4) $display("FAIL bp_count: got %0d want 4", n); else pass_cnt++;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    repeat (3) tick();
    total_cnt++; if (o_tvalid !== 1'b0) $display("FAIL bp_dup: got tvalid %0b want 0", o_tvalid); else pass_cnt++;
  endtask

  task automatic test_drop_empty();
    logic [W-1:0] in_d [3] = '{32'h000000AB, 32'h12345678, 32'hFFFFFFFF};
    logic [B-1:0] in_k [3] = '{4'b0001, 4'b0000, 4'b0000};
    logic         in_l [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] got_d [4];
    logic [B-1:0] got_k [4];
    logic         got_l [4];
    int n = 0;
    o_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) drive(1'b1, in_d[c], in_k[c], in_l[c]);
      else drive(1'b0, 32'h0, 4'h0, 1'b0);
      #1;
      if (o_tvalid && n < 4) begin
        got_d[n] = o_tdata;
        got_k[n] = o_tkeep;
        got_l[n] = o_tlast;
        n++;
      end
      tick();
    end
    total_cnt++; if (n !== 2) $display("FAIL drop_count: got %0d want 2", n); else pass_cnt++;
    if (n >= 2) begin
      total_cnt++; if (got_d[0] !== 32'h000000AB || got_k[0] !== 4'b0001 || got_l[0] !== 1'b0)
        $display("FAIL drop_first: got %h/%b/%0b want 000000ab/0001/0", got_d[0], got_k[0], got_l[0]);
      else pass_cnt++;
      total_cnt++; if (got_d[1] !== 32'h0 || got_k[1] !== 4'b0000 || got_l[1] !== 1'b1)
        $display("FAIL drop_last: got %h/%b/%0b want 00000000/0000/1", got_d[1], got_k[1], got_l[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    o_tready = 1'b1;
    drive(1'b1, 32'h01020304, 4'b1111, 1'b0);
    tick();
    drive(1'b1, 32'h05060708, 4'b0001, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    total_cnt++; if (o_tvalid !== 1'b1) $display("FAIL rstmid_inflight: got %0b want 1", o_tvalid); else pass_cnt++;
    #1;
    aresetn = 1'b0;
    #1;
    total_cnt++; if (o_tvalid !== 1'b0) $display("FAIL rstmid_async_tvalid: got %0b want 0", o_tvalid); else pass_cnt++;
    total_cnt++; if (o_tkeep !== 4'h0 || i_tready !== 1'b1) $display("FAIL rstmid_state: got keep %b tready %0b want 0000 1", o_tkeep, i_tready); else pass_cnt++;
    tick();
    tick();
    aresetn = 1'b1;
    drive(1'b1, 32'hCAFEBABE, 4'b1100, 1'b1);
    for (int c = 0; c < 6 && !found; c++) begin
      #1;
      if (o_tvalid) begin
        found = 1'b1;
        total_cnt++; if (o_tdata !== 32'h0000CAFE || o_tkeep !== 4'b0011 || o_tlast !== 1'b1)
          $display("FAIL rstmid_first: got %h/%b/%0b want 0000cafe/0011/1", o_tdata, o_tkeep, o_tlast);
        else pass_cnt++;
      end
      tick();
      drive(1'b0, 32'h0, 4'h0, 1'b0);
    end
    total_cnt++; if (!found) $display("FAIL rstmid_timeout: got no output want one beat"); else pass_cnt++;
    repeat (3) tick();
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t e;
    logic [W+B-1:0] c;
    logic         in_acc = 1'b0;
    logic         hold   = 1'b0;
    logic [W-1:0] hd = '0;
    logic [B-1:0] hk = '0;
    logic         hl = 1'b0;
    int sent = 0;
    int cyc  = 0;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    while ((sent < N_RAND || q.size() != 0) && cyc < 8000) begin
      if (in_acc) sent++;
      if (!i_tvalid || in_acc) begin
        if (sent < N_RAND && $urandom_range(0, 3) != 0)
          drive(1'b1, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        else
          drive(1'b0, 32'h0, 4'h0, 1'b0);
      end
      o_tready = ($urandom_range(0, 2) != 0);
      #1;
      if (hold) begin
        total_cnt++; if (o_tvalid !== 1'b1 || o_tdata !== hd || o_tkeep !== hk || o_tlast !== hl)
          $display("FAIL rand_stable: got %0b %h/%b/%0b want 1 %h/%b/%0b", o_tvalid, o_tdata, o_tkeep, o_tlast, hd, hk, hl);
        else pass_cnt++;
      end
      in_acc = i_tvalid && i_tready;
      if (in_acc && !(i_tkeep == 4'h0 && !i_tlast)) begin
        c   = compact(i_tdata, i_tkeep);
        e.d = c[W-1:0];
        e.k = c[W+B-1:W];
        e.l = i_tlast;
        q.push_back(e);
      end
      if (o_tvalid && o_tready) begin
        total_cnt++;
        if (q.size() == 0) $display("FAIL rand_extra: got %h/%b want no beat", o_tdata, o_tkeep);
        else begin
          e = q.pop_front();
          if (o_tdata !== e.d || o_tkeep !== e.k || o_tlast !== e.l)
            $display("FAIL rand_beat: got %h/%b/%0b want %h/%b/%0b", o_tdata, o_tkeep, o_tlast, e.d, e.k, e.l);
          else pass_cnt++;
        end
        total_cnt++; if ((o_tkeep & (o_tkeep + 4'd1)) !== 4'd0) $display("FAIL rand_mask: got %b want 2^n-1 form", o_tkeep); else pass_cnt++;
      end
      hold = o_tvalid && !o_tready;
      hd = o_tdata;
      hk = o_tkeep;
      hl = o_tlast;
      cyc++;
      tick();
    end
    total_cnt++; if (sent != N_RAND || q.size() != 0) $display("FAIL rand_drain: got sent %0d pending %0d want %0d 0", sent, q.size(), N_RAND); else pass_cnt++;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    o_tready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drop_empty();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
